// File: rtl/regread_arbiter_pkg.sv
// Shared register-file read definitions: default widths, slot state encoding, pointer sizing.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package regread_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regread_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared read-port arbiter.
// Requests use valid/ready; responses are held by the arbiter until rsp_ready.
interface regread_arbiter_if
    import regread_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ*DATA_W-1:0] rsp_data;
    logic [NUM_REQ-1:0]        rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/regread_arbiter_rr_select.sv
// Round-robin one-hot picker: first set bit of eligible at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_select
    import regread_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest eligible index overwrites the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regread_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters; response valid 1 cycle after grant.
// A full slot that is not draining blocks its requester; a draining slot may capture in the same cycle.
module regread_arbiter
    import regread_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    regread_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] ctrl_readReg,
    input  logic [DATA_W-1:0] data_readReg
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    slot_state_t        slot_state [NUM_REQ];
    logic [DATA_W-1:0]  slot_data  [NUM_REQ];
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] drain;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;

    always_comb begin
        full = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            full[i] = (slot_state[i] == SLOT_FULL);
        end
    end

    assign drain    = full & bus.rsp_ready;
    assign eligible = bus.req_valid & (~full | drain);

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant)
    );

    // A grant seen while reset is low must never complete a handshake.
    assign bus.req_ready = grant & {NUM_REQ{ctrl_reset_n}};
    assign bus.rsp_valid = full;

    always_comb begin
        bus.rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_data[i*DATA_W +: DATA_W] = slot_data[i];
        end
    end

    always_comb begin
        ctrl_readReg = '0;
        ptr_next     = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) begin
                ctrl_readReg = bus.req_addr[i*ADDR_W +: ADDR_W];
                ptr_next     = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ptr <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_state[i] <= SLOT_EMPTY;
                slot_data[i]  <= '0;
            end
        end else begin
            ptr <= ptr_next;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (slot_state[i] == SLOT_EMPTY) begin
                    if (bus.req_ready[i]) begin
                        slot_state[i] <= SLOT_FULL;
                        slot_data[i]  <= data_readReg;
                    end
                end else begin
                    // Capture wins over drain so a back-to-back response is never dropped.
                    if (bus.req_ready[i]) begin
                        slot_data[i] <= data_readReg;
                    end else if (bus.rsp_ready[i]) begin
                        slot_state[i] <= SLOT_EMPTY;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regread_arbiter.sv
// Bench for regread_arbiter: directed vector table, corner-case sequences, random traffic vs a model.
module tb_regread_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clock;
    logic          ctrl_reset_n;
    logic [AW-1:0] ctrl_readReg;
    logic [DW-1:0] data_readReg;
    logic [DW-1:0] regs [32];

    regread_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regread_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg)
    );

    assign data_readReg = regs[ctrl_readReg];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: slot occupancy, held data and the round-robin start index.
    int            m_ptr;
    bit            m_full [NR];
    logic [DW-1:0] m_data [NR];

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NR; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return bus.req_addr[i*AW +: AW];
    endfunction

    function automatic int exp_grant();
        if (!ctrl_reset_n) return -1;
        for (int k = 0; k < NR; k++) begin
            int i = (m_ptr + k) % NR;
            if (bus.req_valid[i] && (!m_full[i] || bus.rsp_ready[i])) return i;
        end
        return -1;
    endfunction

    task automatic model_check(input string tag);
        int            g;
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_vld;
        g       = exp_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ".req_ready"}, bus.req_ready, exp_rdy);
        chk({tag, ".readReg"}, ctrl_readReg, (g >= 0) ? addr_of(g) : '0);
        for (int i = 0; i < NR; i++) exp_vld[i] = m_full[i];
        chk({tag, ".rsp_valid"}, bus.rsp_valid, exp_vld);
        for (int i = 0; i < NR; i++)
            if (m_full[i]) chk({tag, ".rsp_data"}, bus.rsp_data[i*DW +: DW], m_data[i]);
    endtask

    task automatic apply(input int g);
        if (!ctrl_reset_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NR; i++) begin
            if (i == g) begin
                m_full[i] = 1'b1;
                m_data[i] = regs[addr_of(i)];
            end else if (m_full[i] && bus.rsp_ready[i]) begin
                m_full[i] = 1'b0;
            end
        end
        if (g >= 0) m_ptr = (g + 1) % NR;
    endtask

    // Call after the negedge; checks the model, then crosses the posedge.
    task automatic tick(input string tag, output int g);
        model_check(tag);
        g = exp_grant();
        @(posedge clock);
        apply(g);
        #1;
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] rr;
        logic [NR-1:0] exp_ready;
        logic [AW-1:0] exp_addr;
        logic [NR-1:0] exp_rsp_valid;
        int            exp_slot;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tv [4];
    int   g;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hD00D_0000 + i * 32'h0001_0203;

        tv[0] = '{3'b111, 3'b111, 3'b001, 5'd5,  3'b000, -1, 32'h0};
        tv[1] = '{3'b110, 3'b111, 3'b010, 5'd9,  3'b001,  0, regs[5]};
        tv[2] = '{3'b100, 3'b111, 3'b100, 5'd12, 3'b010,  1, regs[9]};
        tv[3] = '{3'b000, 3'b111, 3'b000, 5'd0,  3'b100,  2, regs[12]};

        // Reset with every requester already asking: nothing may be granted.
        ctrl_reset_n  = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd12, 5'd9, 5'd5};
        bus.rsp_ready = 3'b111;
        model_reset();
        #3;
        chk("reset.req_ready", bus.req_ready, 3'b000);
        chk("reset.rsp_valid", bus.rsp_valid, 3'b000);
        chk("reset.rsp_data", bus.rsp_data, '0);
        chk("reset.readReg", ctrl_readReg, '0);
        @(posedge clock);
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;

        // Grants 0,1,2 on consecutive cycles, each response one cycle later.
        for (int t = 0; t < 4; t++) begin
            bus.req_valid = tv[t].valid;
            bus.rsp_ready = tv[t].rr;
            @(negedge clock);
            chk($sformatf("tbl%0d.req_ready", t), bus.req_ready, tv[t].exp_ready);
            chk($sformatf("tbl%0d.readReg", t), ctrl_readReg, tv[t].exp_addr);
            chk($sformatf("tbl%0d.rsp_valid", t), bus.rsp_valid, tv[t].exp_rsp_valid);
            if (tv[t].exp_slot >= 0)
                chk($sformatf("tbl%0d.rsp_data", t),
                    bus.rsp_data[tv[t].exp_slot*DW +: DW], tv[t].exp_data);
            tick("tbl", g);
        end

        // Requester 1 stalls its response: it must be skipped while 0 wins every cycle.
        bus.req_addr  = {5'd0, 5'd2, 5'd1};
        bus.rsp_ready = 3'b101;
        bus.req_valid = 3'b010;
        @(negedge clock);
        chk("stall.fill1", bus.req_ready, 3'b010);
        tick("stall", g);
        bus.req_valid = 3'b011;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk($sformatf("stall%0d.no_grant1", c), bus.req_ready[1], 1'b0);
            chk($sformatf("stall%0d.grant0", c), bus.req_ready[0], 1'b1);
            tick("stall", g);
        end
        bus.req_valid = 3'b000;
        bus.rsp_ready = 3'b111;
        for (int c = 0; c < 2; c++) begin @(negedge clock); tick("drain", g); end

        // Slot 2 drains and recaptures at the same edge.
        bus.req_addr  = {5'd7, 5'd0, 5'd0};
        bus.req_valid = 3'b100;
        bus.rsp_ready = 3'b000;
        @(negedge clock); tick("swap.fill", g);
        bus.req_addr  = {5'd20, 5'd0, 5'd0};
        bus.rsp_ready = 3'b100;
        @(negedge clock);
        chk("swap.grant2", bus.req_ready, 3'b100);
        chk("swap.old_data", bus.rsp_data[2*DW +: DW], regs[7]);
        tick("swap", g);
        bus.req_valid = 3'b000;
        bus.rsp_ready = 3'b000;
        @(negedge clock);
        chk("swap.still_valid", bus.rsp_valid[2], 1'b1);
        chk("swap.new_data", bus.rsp_data[2*DW +: DW], regs[20]);
        tick("swap", g);
        bus.rsp_ready = 3'b111;
        for (int c = 0; c < 2; c++) begin @(negedge clock); tick("drain", g); end

        // Reset mid-stream with slot 0 full clears outputs without waiting for a clock.
        bus.req_addr  = {5'd4, 5'd6, 5'd3};
        bus.req_valid = 3'b001;
        bus.rsp_ready = 3'b000;
        @(negedge clock); tick("mid.fill", g);
        bus.req_valid = 3'b111;
        ctrl_reset_n  = 1'b0;
        model_reset();
        #1;
        chk("mid.rsp_valid", bus.rsp_valid, 3'b000);
        chk("mid.req_ready", bus.req_ready, 3'b000);
        chk("mid.rsp_data", bus.rsp_data, '0);
        @(negedge clock); tick("mid.rst", g);
        ctrl_reset_n  = 1'b1;
        bus.req_valid = 3'b110;
        bus.rsp_ready = 3'b111;
        @(negedge clock);
        chk("mid.first_grant", bus.req_ready, 3'b010);
        tick("mid", g);
        bus.req_valid = 3'b000;
        for (int c = 0; c < 2; c++) begin @(negedge clock); tick("drain", g); end

        // Single requester on index 31 with the consumer stalled for four cycles.
        bus.req_addr  = {5'd0, 5'd0, 5'd31};
        bus.req_valid = 3'b001;
        bus.rsp_ready = 3'b000;
        @(negedge clock);
        chk("hold.grant", bus.req_ready, 3'b001);
        tick("hold", g);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk($sformatf("hold%0d.no_grant", c), bus.req_ready, 3'b000);
            chk($sformatf("hold%0d.valid", c), bus.rsp_valid[0], 1'b1);
            chk($sformatf("hold%0d.data", c), bus.rsp_data[0 +: DW], regs[31]);
            tick("hold", g);
        end
        bus.rsp_ready = 3'b001;
        @(negedge clock);
        chk("hold.regrant", bus.req_ready, 3'b001);
        tick("hold", g);
        bus.req_valid = 3'b000;
        bus.rsp_ready = 3'b111;
        for (int c = 0; c < 2; c++) begin @(negedge clock); tick("drain", g); end

        // Random traffic; each requester holds its request until granted.
        for (int c = 0; c < 400; c++) begin
            bus.rsp_ready = NR'($urandom_range(0, (1 << NR) - 1));
            @(negedge clock);
            tick("rand", g);
            for (int i = 0; i < NR; i++) begin
                if (i == g || !bus.req_valid[i]) begin
                    bus.req_valid[i]          = ($urandom_range(0, 9) < 6);
                    bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
